// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-deep chain of registered pipeline stages with a
// valid/ready handshake on each end. Stages advance whenever the stage
// ahead of them can accept, so bubbles collapse and stalls back-pressure
// cleanly. A synchronous flush squashes every stage, and the registered
// occupancy count is exported for hazard and debug logic.
//
// The ready chain is combinational from out_ready to in_ready. The data
// path is fully registered: there is no combinational path from data_ip
// to data_op.

module pipe_stage_reg #(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           DEPTH       = 2,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   // Derived width of the occupancy output; leave at its default.
   parameter int unsigned           CNT_WIDTH   = $clog2(DEPTH + 1)
) (
   input  logic                  clock,
   input  logic                  reset,      // asynchronous, active low
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] data_ip,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_op,
   output logic [CNT_WIDTH-1:0]  occupancy
);

   // A zero-depth or zero-width pipe has no meaning; stop elaboration.
   if (DEPTH < 1) begin : g_depth_check
      $error("pipe_stage_reg: DEPTH must be at least 1");
   end
   if (DATA_WIDTH < 1) begin : g_width_check
      $error("pipe_stage_reg: DATA_WIDTH must be at least 1");
   end

   // -----------------------------------------------------------------
   // Stage state
   // -----------------------------------------------------------------
   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_d [DEPTH];
   logic [CNT_WIDTH-1:0]  occ_q, occ_d;

   // adv[i] = 1 when stage i may load this cycle; adv[DEPTH] is the
   // downstream consumer.
   logic [DEPTH:0]        adv;

   // What each stage would load if it advances: the previous stage's
   // contents, or the upstream handshake for stage 0.
   logic [DEPTH-1:0]      in_v;
   logic [DATA_WIDTH-1:0] in_data [DEPTH];

   // -----------------------------------------------------------------
   // Acceptance chain: a stage can load when it is empty or when the
   // stage ahead of it is itself able to move on.
   // -----------------------------------------------------------------
   always_comb begin
      // NOTE: every variable in a combinational block gets a default
      // before any conditional code, so no path can infer a latch.
      adv        = '0;
      adv[DEPTH] = out_ready;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         adv[i] = ~valid_q[i] | adv[i+1];
      end
   end

   // Upstream handshake is refused while squashing so that nothing is
   // half-accepted in a flush cycle.
   assign in_ready = adv[0] & ~flush;

   // Source selection for each stage: stage 0 takes the upstream word,
   // every later stage takes its predecessor.
   always_comb begin
      in_v       = '0;
      in_v[0]    = in_valid & in_ready;
      in_data[0] = data_ip;
      for (int i = 1; i < int'(DEPTH); i++) begin
         in_v[i]    = valid_q[i-1];
         in_data[i] = data_q[i-1];
      end
   end

   // Next-state: flush clears all valid bits and leaves data alone;
   // otherwise each advancing stage takes its source, and data is only
   // overwritten by a real word so bubbles never disturb data_op.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      occ_d   = '0;
      if (flush) begin
         valid_d = '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (adv[i]) begin
               valid_d[i] = in_v[i];
               if (in_v[i]) begin
                  data_d[i] = in_data[i];
               end
            end
         end
      end
      // Occupancy is the popcount of the next valid vector, so the
      // registered count moves on the same edge as the valid bits.
      for (int i = 0; i < int'(DEPTH); i++) begin
         occ_d = occ_d + CNT_WIDTH'(valid_d[i]);
      end
   end

   // Valid bits, occupancy and stage data registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments only, so
         // every flop samples the values from before this edge.
         valid_q <= '0;
         occ_q   <= '0;
         // NOTE: the data registers are reset too: data_op must read
         // RESET_VALUE during reset, not whatever the last word was.
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= RESET_VALUE;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         data_q  <= data_d;
      end
   end

   // -----------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------
   assign out_valid = valid_q[DEPTH-1] & ~flush;
   assign data_op   = data_q[DEPTH-1];
   assign occupancy = occ_q;

   // -----------------------------------------------------------------
   // Invariants
   // -----------------------------------------------------------------
`ifndef SYNTHESIS
   // The count never exceeds the number of stages.
   a_occ_range : assert property (@(posedge clock) disable iff (!reset)
      occ_q <= CNT_WIDTH'(DEPTH));

   // The registered count always agrees with the valid bits.
   a_occ_match : assert property (@(posedge clock) disable iff (!reset)
      int'(occ_q) == $countones(valid_q));

   // A stalled output word is held stable until it is taken.
   a_hold_stall : assert property (@(posedge clock) disable iff (!reset)
      (out_valid && !out_ready) |=> $stable(data_op));
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a DEPTH=3 instance driven by a
// table of directed vectors, hand-written flush and reset sequences and a
// randomized run against a position-based reference model, plus a
// DEPTH=1 instance exercised with alternating back-pressure.

module tb_pipe_stage_reg;

   localparam int          D3  = 3;
   localparam logic [31:0] RV3 = 32'hDEAD_BEEF;
   localparam logic [31:0] RV1 = 32'h1234_5678;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   // DEPTH=3 instance
   logic        d3_flush, d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
   logic [31:0] d3_data_ip, d3_data_op;
   logic [1:0]  d3_occ;

   // DEPTH=1 instance
   logic        d1_flush, d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
   logic [31:0] d1_data_ip, d1_data_op;
   logic [0:0]  d1_occ;

   pipe_stage_reg #(.DATA_WIDTH(32), .DEPTH(D3), .RESET_VALUE(RV3)) u_dut3 (
      .clock     (clock),
      .reset     (reset),
      .flush     (d3_flush),
      .in_valid  (d3_in_valid),
      .in_ready  (d3_in_ready),
      .data_ip   (d3_data_ip),
      .out_valid (d3_out_valid),
      .out_ready (d3_out_ready),
      .data_op   (d3_data_op),
      .occupancy (d3_occ)
   );

   pipe_stage_reg #(.DATA_WIDTH(32), .DEPTH(1), .RESET_VALUE(RV1)) u_dut1 (
      .clock     (clock),
      .reset     (reset),
      .flush     (d1_flush),
      .in_valid  (d1_in_valid),
      .in_ready  (d1_in_ready),
      .data_ip   (d1_data_ip),
      .out_valid (d1_out_valid),
      .out_ready (d1_out_ready),
      .data_op   (d1_data_op),
      .occupancy (d1_occ)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive3(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
      d3_in_valid  = iv;
      d3_data_ip   = d;
      d3_out_ready = ordy;
      d3_flush     = fl;
   endtask

   task automatic check3(input string tag, input logic e_ir, input logic e_ov,
                         input logic [31:0] e_dop, input logic [1:0] e_occ);
      check($sformatf("%s in_ready", tag),  32'(d3_in_ready),  32'(e_ir));
      check($sformatf("%s out_valid", tag), 32'(d3_out_valid), 32'(e_ov));
      check($sformatf("%s data_op", tag),   d3_data_op,        e_dop);
      check($sformatf("%s occupancy", tag), 32'(d3_occ),       32'(e_occ));
   endtask

   // One cycle on the DEPTH=3 instance: drive, settle, compare, then move
   // to the next falling edge (the rising edge commits in between).
   task automatic cyc3(input string tag, input logic iv, input logic [31:0] d,
                       input logic ordy, input logic fl, input logic e_ir,
                       input logic e_ov, input logic [31:0] e_dop, input logic [1:0] e_occ);
      drive3(iv, d, ordy, fl);
      #1;
      check3(tag, e_ir, e_ov, e_dop, e_occ);
      @(negedge clock);
   endtask

   // ------------------------------------------------------------------
   // Directed vector table
   // ------------------------------------------------------------------
   typedef struct {
      logic        in_valid;
      logic [31:0] data_ip;
      logic        out_ready;
      logic        flush;
      logic        exp_in_ready;
      logic        exp_out_valid;
      logic [31:0] exp_data_op;
      logic [1:0]  exp_occ;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                               input logic fl, input logic e_ir, input logic e_ov,
                               input logic [31:0] e_dop, input logic [1:0] e_occ);
      vec_t v;
      v.in_valid      = iv;
      v.data_ip       = d;
      v.out_ready     = ordy;
      v.flush         = fl;
      v.exp_in_ready  = e_ir;
      v.exp_out_valid = e_ov;
      v.exp_data_op   = e_dop;
      v.exp_occ       = e_occ;
      return v;
   endfunction

   // ------------------------------------------------------------------
   // Reference model for the random run: a list of words, oldest first,
   // each tagged with the stage it sits in. Every cycle the oldest word
   // leaves from the last stage if the consumer is ready, and each word
   // slides one stage forward unless the word ahead of it blocks it.
   // ------------------------------------------------------------------
   typedef struct {
      logic [31:0] data;
      int          pos;
   } item_t;

   item_t       model_q[$];
   logic [31:0] model_last;

   task automatic model_cycle(input string tag, input logic iv, input logic [31:0] d,
                              input logic ordy, input logic fl);
      item_t nxt[$];
      item_t it;
      int    lim;
      logic  e_ir, e_ov;
      lim = D3 - 1;
      for (int j = 0; j < model_q.size(); j++) begin
         it = model_q[j];
         if (!(j == 0 && it.pos == D3 - 1 && ordy && !fl)) begin
            it.pos = (it.pos + 1 < lim) ? it.pos + 1 : lim;
            lim    = it.pos - 1;
            nxt.push_back(it);
         end
      end
      e_ir = !fl && (lim >= 0);
      e_ov = !fl && (model_q.size() > 0) && (model_q[0].pos == D3 - 1);
      drive3(iv, d, ordy, fl);
      #1;
      check3(tag, e_ir, e_ov, model_last, 2'(model_q.size()));
      if (fl) begin
         model_q.delete();
      end else begin
         if (nxt.size() > 0 && nxt[0].pos == D3 - 1) model_last = nxt[0].data;
         if (iv && e_ir) begin
            it.data = d;
            it.pos  = 0;
            nxt.push_back(it);
         end
         model_q = nxt;
      end
      @(negedge clock);
   endtask

   // Safety net so the run always ends.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d1_q[$];
      int          d1_xfers;
      logic [31:0] d1_next;
      logic        e_ir1, e_ov1;

      drive3(1'b0, 32'h0, 1'b0, 1'b0);
      d1_flush = 1'b0; d1_in_valid = 1'b0; d1_data_ip = '0; d1_out_ready = 1'b0;

      // Table: single-word latency, streaming, back-pressure.
      vecs.push_back(mk(1, 32'hA5A5_0001, 1, 0,  1, 0, RV3,           2'd0));
      vecs.push_back(mk(0, 32'h0,         1, 0,  1, 0, RV3,           2'd1));
      vecs.push_back(mk(0, 32'h0,         1, 0,  1, 0, RV3,           2'd1));
      vecs.push_back(mk(0, 32'h0,         1, 0,  1, 1, 32'hA5A5_0001, 2'd1));
      vecs.push_back(mk(0, 32'h0,         1, 0,  1, 0, 32'hA5A5_0001, 2'd0));
      for (int k = 0; k < 12; k++) begin
         int pushed, emitted;
         pushed  = (k < 8) ? k : 8;
         emitted = (k < 3) ? 0 : ((k < 11) ? k - 3 : 8);
         vecs.push_back(mk(k < 8, (k < 8) ? 32'(32'h10 + k) : 32'h0, 1, 0, 1,
                           (k >= 3) && (k <= 10),
                           (k < 3) ? 32'hA5A5_0001 : 32'(32'h10 + ((k <= 10) ? k - 3 : 7)),
                           2'(pushed - emitted)));
      end
      vecs.push_back(mk(1, 32'h1, 0, 0,  1, 0, 32'h17, 2'd0));
      vecs.push_back(mk(1, 32'h2, 0, 0,  1, 0, 32'h17, 2'd1));
      vecs.push_back(mk(1, 32'h3, 0, 0,  1, 0, 32'h17, 2'd2));
      vecs.push_back(mk(1, 32'h4, 0, 0,  0, 1, 32'h1,  2'd3));
      vecs.push_back(mk(1, 32'h4, 1, 0,  1, 1, 32'h1,  2'd3));
      vecs.push_back(mk(0, 32'h0, 1, 0,  1, 1, 32'h2,  2'd3));
      vecs.push_back(mk(0, 32'h0, 1, 0,  1, 1, 32'h3,  2'd2));
      vecs.push_back(mk(0, 32'h0, 1, 0,  1, 1, 32'h4,  2'd1));
      vecs.push_back(mk(0, 32'h0, 1, 0,  1, 0, 32'h4,  2'd0));

      // Asynchronous reset with no clock edge yet.
      #2 reset = 1'b0;
      #1;
      check("reset d3 out_valid", 32'(d3_out_valid), 32'd0);
      check("reset d3 data_op",   d3_data_op,        RV3);
      check("reset d3 occupancy", 32'(d3_occ),       32'd0);
      check("reset d1 out_valid", 32'(d1_out_valid), 32'd0);
      check("reset d1 data_op",   d1_data_op,        RV1);
      check("reset d1 occupancy", 32'(d1_occ),       32'd0);

      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < vecs.size(); k++) begin
         cyc3($sformatf("vec%0d", k), vecs[k].in_valid, vecs[k].data_ip, vecs[k].out_ready,
              vecs[k].flush, vecs[k].exp_in_ready, vecs[k].exp_out_valid,
              vecs[k].exp_data_op, vecs[k].exp_occ);
      end

      // Flush with a word presented in the same cycle: nothing is taken.
      cyc3("fl0", 1, 32'h7, 0, 0,  1, 0, 32'h4, 2'd0);
      cyc3("fl1", 1, 32'h8, 0, 0,  1, 0, 32'h4, 2'd1);
      cyc3("fl2", 0, 32'h0, 0, 0,  1, 0, 32'h4, 2'd2);
      cyc3("fl3", 1, 32'h9, 1, 1,  0, 0, 32'h7, 2'd2);
      cyc3("fl4", 0, 32'h0, 1, 0,  1, 0, 32'h7, 2'd0);
      cyc3("fl5", 1, 32'h9, 1, 0,  1, 0, 32'h7, 2'd0);
      cyc3("fl6", 0, 32'h0, 1, 0,  1, 0, 32'h7, 2'd1);
      cyc3("fl7", 0, 32'h0, 1, 0,  1, 0, 32'h7, 2'd1);
      cyc3("fl8", 0, 32'h0, 1, 0,  1, 1, 32'h9, 2'd1);
      cyc3("fl9", 0, 32'h0, 1, 0,  1, 0, 32'h9, 2'd0);

      // Reset asserted between edges with a full, stalled pipe.
      cyc3("rf0", 1, 32'h31, 0, 0,  1, 0, 32'h9, 2'd0);
      cyc3("rf1", 1, 32'h32, 0, 0,  1, 0, 32'h9, 2'd1);
      cyc3("rf2", 1, 32'h33, 0, 0,  1, 0, 32'h9, 2'd2);
      drive3(1'b1, 32'h34, 1'b0, 1'b0);
      #1;
      check3("full", 1'b0, 1'b1, 32'h31, 2'd3);
      #1 reset = 1'b0;
      #1;
      check("midreset out_valid", 32'(d3_out_valid), 32'd0);
      check("midreset data_op",   d3_data_op,        RV3);
      check("midreset occupancy", 32'(d3_occ),       32'd0);
      @(negedge clock);
      reset = 1'b1;
      cyc3("rs0", 1, 32'h40, 1, 0,  1, 0, RV3,    2'd0);
      cyc3("rs1", 0, 32'h0,  1, 0,  1, 0, RV3,    2'd1);
      cyc3("rs2", 0, 32'h0,  1, 0,  1, 0, RV3,    2'd1);
      cyc3("rs3", 0, 32'h0,  1, 0,  1, 1, 32'h40, 2'd1);
      cyc3("rs4", 0, 32'h0,  1, 0,  1, 0, 32'h40, 2'd0);

      // DEPTH=1: always presenting, consumer ready every other cycle.
      d1_xfers = 0;
      d1_next  = 32'h100;
      for (int c = 0; c < 80 && d1_xfers < 16; c++) begin
         d1_in_valid  = 1'b1;
         d1_data_ip   = d1_next;
         d1_out_ready = (c % 2 == 0);
         #1;
         e_ov1 = (d1_q.size() != 0);
         e_ir1 = !e_ov1 || d1_out_ready;
         check($sformatf("d1 c%0d in_ready", c),  32'(d1_in_ready),  32'(e_ir1));
         check($sformatf("d1 c%0d out_valid", c), 32'(d1_out_valid), 32'(e_ov1));
         if (e_ov1 && d1_out_ready) begin
            check($sformatf("d1 xfer%0d data_op", d1_xfers), d1_data_op,
                  32'(32'h100 + d1_xfers));
            void'(d1_q.pop_front());
            d1_xfers++;
         end
         if (e_ir1) begin
            d1_q.push_back(d1_next);
            d1_next++;
         end
         @(negedge clock);
      end
      check("d1 transfers done", 32'(d1_xfers), 32'd16);
      d1_in_valid  = 1'b0;
      d1_out_ready = 1'b0;

      // Randomized run against the reference model, from a clean reset.
      drive3(1'b0, 32'h0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      model_q.delete();
      model_last = RV3;
      for (int c = 0; c < 300; c++) begin
         model_cycle($sformatf("rnd%0d", c), $urandom_range(0, 3) != 0, $urandom,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the single enable-gated pipeline flop: a chain of DEPTH registered stages, each DATA_WIDTH wide, with a valid/ready handshake per end.
- Bubble-collapsing: a stage advances whenever the stage after it can accept, so stalls back-pressure cleanly.
- Supports a synchronous flush for branch/exception squash between datapath stages of the core.
- Exports the current occupancy for hazard and debug logic.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, number of register stages (>=1; elaboration error if 0).
- RESET_VALUE, 0, value loaded into every data register on reset (DATA_WIDTH bits).
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy output (derived; not to be overridden).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous squash of all stages.
- in_valid  input  1  upstream presents data_ip.
- in_ready  output  1  stage 0 can accept this cycle.
- data_ip  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  data_op is valid.
- out_ready  input  1  downstream accepts data_op.
- data_op  output  DATA_WIDTH  payload of the last stage.
- occupancy  output  CNT_WIDTH  number of valid stages, 0..DEPTH.

Behaviour:
- State: per stage i (0..DEPTH-1), data[i] and valid[i]. Stage 0 is the input end; stage DEPTH-1 drives data_op.
- Reset (reset=0, asynchronous): all valid[i]=0 and all data[i]=RESET_VALUE, effective immediately without a clock edge. In reset, out_valid=0, data_op=RESET_VALUE, occupancy=0.
- Release is synchronous to clock; the first transfer is possible on the first rising edge after release.
- Reset asserted mid-transfer discards all contents; no partial state survives.
- Acceptance terms (combinational):
  - adv[DEPTH] = out_ready.
  - adv[i] = !valid[i] | adv[i+1].
  - in_ready = adv[0] & !flush.
- Each rising edge, when not flushing, stage i loads from stage i-1 (or data_ip for i=0) when adv[i]=1:
  - valid[i] <= valid[i-1], or in_valid&in_ready for i=0.
  - data[i] is written only when the incoming valid is 1. Bubbles do not overwrite data, so data_op holds its last value while out_valid=0.
- When adv[i]=0 the stage holds both data and valid.
- Output: out_valid = valid[DEPTH-1] & !flush; data_op = data[DEPTH-1]. A transfer occurs when out_valid & out_ready.
- Latency: a word accepted in cycle t with an empty, unstalled pipe is presented with out_valid=1 in cycle t+DEPTH.
- Throughput: 1 word/cycle while out_ready=1 continuously.
- Full: all valid=1 and out_ready=0 gives in_ready=0. If out_ready=1 in the same cycle, in_ready=1: simultaneous accept and emit, occupancy unchanged.
- Empty: out_valid=0; out_ready is ignored.
- Flush (synchronous, highest priority below reset): on the edge, all valid[i] <= 0 and data registers are unchanged.
  - In the flush cycle, in_ready=0 and out_valid=0, so no handshake completes on either side.
  - The next cycle has occupancy=0 and in_ready=1.
- occupancy: registered popcount of valid[], updated on the same edge as valid[].
- DEPTH=1: a single register with combinational in_ready = !valid[0] | out_ready, which gives full throughput.
- No combinational path from data_ip to data_op. The ready chain is combinational out_ready -> in_ready, which is documented and accepted.

Test Plan:
- DEPTH=3, empty pipe, out_ready=1; push 0xA5A5_0001 in cycle 0 -> out_valid=1 with data_op=0xA5A5_0001 in cycle 3 only. Occupancy reads 1 in cycles 1-3, then 0.
- DEPTH=3, streaming 0x10..0x17 on consecutive cycles with out_ready=1 -> outputs 0x10..0x17 on consecutive cycles starting cycle 3, in_ready constantly 1, occupancy steady at 3.
- DEPTH=3, out_ready=0, push 0x1,0x2,0x3,0x4 -> first three accepted, in_ready=0 on the 4th, occupancy=3. Raise out_ready -> 0x4 accepted in the same cycle 0x1 emits, then order is 0x2,0x3,0x4.
- Pipe holding 0x7,0x8 with flush=1 and in_valid=1 (0x9) in the same cycle -> no handshake that cycle. Next cycle occupancy=0 and out_valid=0; 0x9 is not captured and must be re-presented.
- RESET_VALUE=0xDEAD_BEEF, pipe full; drive reset=0 between clock edges -> out_valid=0, data_op=0xDEAD_BEEF, occupancy=0 before the next edge. Post-release, the first push is accepted on the first edge.
- DEPTH=1, alternating out_ready 1/0 with in_valid=1 -> in_ready mirrors !valid | out_ready, with no lost or duplicated words over 16 transfers.
